// File: rtl/arm_pipelined_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module : arm_pipelined_decode_buffer
// Brief  : Instruction queue feeding a registered ARM main/ALU decoder stage.
// Rev    : 1.0  initial release
// ============================================================================
module arm_pipelined_decode_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       i_CLK,
  input  logic                       i_NRESET,
  input  logic                       i_Instr_Valid,
  input  logic [31:0]                i_Instr,
  output logic                       o_Instr_Ready,
  input  logic                       i_Stall,
  input  logic                       i_Flush,
  output logic                       o_Valid_Decode,
  output logic [3:0]                 o_Cond_Decode,
  output logic [3:0]                 o_Rd_Decode,
  output logic [1:0]                 o_Flag_Write_Decode,
  output logic [2:0]                 o_ALU_Control_Decode,
  output logic [1:0]                 o_Reg_Src_Decode,
  output logic [1:0]                 o_Imm_Src_Decode,
  output logic                       o_PC_Src_Decode,
  output logic                       o_Reg_Write_Decode,
  output logic                       o_Mem_Write_Decode,
  output logic                       o_Mem_To_Reg_Decode,
  output logic                       o_ALU_Src_Decode,
  output logic                       o_Branch_Decode,
  output logic                       o_No_Write_Decode,
  output logic                       o_Undef_Decode,
  output logic [$clog2(DEPTH+1)-1:0] o_Occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0] cond;
    logic [3:0] rd;
    logic [1:0] flag_w;
    logic [2:0] alu_ctrl;
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       pc_src;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       no_write;
    logic       undef;
  } dec_t;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  dec_t          r_dec;
  dec_t          w_dec;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head;
  logic [1:0]    w_op;
  logic          w_i_bit;
  logic [3:0]    w_cmd;
  logic          w_s_bit;
  logic          w_unused_bits;

  assign o_Instr_Ready = (r_count < CW'(DEPTH));
  assign w_push        = i_Instr_Valid && o_Instr_Ready && !i_Flush;
  assign w_pop         = !i_Flush && (r_count != '0) && (!r_valid || !i_Stall);

  assign w_head        = r_mem[r_rd_ptr];
  assign w_op          = w_head[27:26];
  assign w_i_bit       = w_head[25];
  assign w_cmd         = w_head[24:21];
  assign w_s_bit       = w_head[20];
  assign w_unused_bits = ^{w_head[19:16], w_head[11:0]};

  // Storage carries no reset; only entries between the pointers are meaningful.
  always_ff @(posedge i_CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_Instr;
    end
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_dec      = '0;
    w_dec.cond = w_head[31:28];
    w_dec.rd   = w_head[15:12];
    case (w_op)
      2'b00: begin
        w_dec.reg_w   = 1'b1;
        w_dec.alu_src = w_i_bit;
        case (w_cmd)
          4'b0100: w_dec.alu_ctrl = 3'b000;
          4'b0010: w_dec.alu_ctrl = 3'b001;
          4'b0000: w_dec.alu_ctrl = 3'b010;
          4'b1100: w_dec.alu_ctrl = 3'b011;
          4'b0001: w_dec.alu_ctrl = 3'b100;
          4'b1101: w_dec.alu_ctrl = 3'b101;
          4'b1010: begin w_dec.alu_ctrl = 3'b001; w_dec.no_write = 1'b1; end
          4'b1000: begin w_dec.alu_ctrl = 3'b010; w_dec.no_write = 1'b1; end
          4'b1011: begin w_dec.alu_ctrl = 3'b000; w_dec.no_write = 1'b1; end
          default: w_dec.undef = 1'b1;
        endcase
        w_dec.flag_w[1] = w_s_bit;
        w_dec.flag_w[0] = w_s_bit && (w_cmd == 4'b0100 || w_cmd == 4'b0010 ||
                                      w_cmd == 4'b1010 || w_cmd == 4'b1011);
        if (w_dec.no_write) begin
          w_dec.reg_w = 1'b0;
          if (!w_s_bit) w_dec.undef = 1'b1;
        end
      end
      2'b01: begin
        w_dec.alu_src = 1'b1;
        w_dec.imm_src = 2'b01;
        if (w_s_bit) begin
          w_dec.reg_w      = 1'b1;
          w_dec.mem_to_reg = 1'b1;
        end else begin
          w_dec.mem_w   = 1'b1;
          w_dec.reg_src = 2'b10;
        end
      end
      2'b10: begin
        w_dec.branch  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.imm_src = 2'b10;
        w_dec.reg_src = 2'b01;
      end
      default: w_dec.undef = 1'b1;
    endcase
    // An undefined encoding keeps only its condition/destination fields.
    if (w_dec.undef) begin
      w_dec          = '0;
      w_dec.cond     = w_head[31:28];
      w_dec.rd       = w_head[15:12];
      w_dec.undef    = 1'b1;
    end
    w_dec.pc_src = w_dec.branch || (w_dec.reg_w && (w_dec.rd == 4'hF));
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
    end else if (i_Flush) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_dec   <= w_dec;
    end else if (!i_Stall) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
    end
  end

  assign o_Valid_Decode       = r_valid;
  assign o_Cond_Decode        = r_dec.cond;
  assign o_Rd_Decode          = r_dec.rd;
  assign o_Flag_Write_Decode  = r_dec.flag_w;
  assign o_ALU_Control_Decode = r_dec.alu_ctrl;
  assign o_Reg_Src_Decode     = r_dec.reg_src;
  assign o_Imm_Src_Decode     = r_dec.imm_src;
  assign o_PC_Src_Decode      = r_dec.pc_src;
  assign o_Reg_Write_Decode   = r_dec.reg_w;
  assign o_Mem_Write_Decode   = r_dec.mem_w;
  assign o_Mem_To_Reg_Decode  = r_dec.mem_to_reg;
  assign o_ALU_Src_Decode     = r_dec.alu_src;
  assign o_Branch_Decode      = r_dec.branch;
  assign o_No_Write_Decode    = r_dec.no_write;
  assign o_Undef_Decode       = r_dec.undef;
  assign o_Occupancy          = r_count;

endmodule
`default_nettype wire

// File: tb/tb_arm_pipelined_decode_buffer.sv
`default_nettype none
// Directed bench for arm_pipelined_decode_buffer with an expected-decode queue.
module tb_arm_pipelined_decode_buffer;

  localparam int DEPTH = 4;
  localparam int NT    = 11;

  logic        clk = 1'b0;
  logic        nreset;
  logic        instr_valid, stall, flush;
  logic [31:0] instr;
  logic        instr_ready, valid_d, pc_src, reg_w, mem_w, mem_to_reg, alu_src, branch, no_write, undef;
  logic [3:0]  cond, rd;
  logic [1:0]  flag_w, reg_src, imm_src;
  logic [2:0]  alu_ctrl;
  logic [2:0]  occ;

  arm_pipelined_decode_buffer #(.DEPTH(DEPTH)) dut (
    .i_CLK(clk), .i_NRESET(nreset), .i_Instr_Valid(instr_valid), .i_Instr(instr),
    .o_Instr_Ready(instr_ready), .i_Stall(stall), .i_Flush(flush), .o_Valid_Decode(valid_d),
    .o_Cond_Decode(cond), .o_Rd_Decode(rd), .o_Flag_Write_Decode(flag_w),
    .o_ALU_Control_Decode(alu_ctrl), .o_Reg_Src_Decode(reg_src), .o_Imm_Src_Decode(imm_src),
    .o_PC_Src_Decode(pc_src), .o_Reg_Write_Decode(reg_w), .o_Mem_Write_Decode(mem_w),
    .o_Mem_To_Reg_Decode(mem_to_reg), .o_ALU_Src_Decode(alu_src), .o_Branch_Decode(branch),
    .o_No_Write_Decode(no_write), .o_Undef_Decode(undef), .o_Occupancy(occ)
  );

  always #5 clk = ~clk;

  logic [24:0] act;
  assign act = {cond, rd, flag_w, alu_ctrl, reg_src, imm_src,
                pc_src, reg_w, mem_w, mem_to_reg, alu_src, branch, no_write, undef};

  int          n_vec = 0;
  int          n_err = 0;
  logic [24:0] exp_q[$];
  logic [24:0] m_cur;
  int          m_cnt;
  bit          m_valid;
  logic [31:0] t_ins [NT];
  logic [24:0] t_exp [NT];

  function automatic logic [24:0] mk(input logic [3:0] c, input logic [3:0] r,
                                     input logic [1:0] fw, input logic [2:0] al,
                                     input logic [1:0] rs, input logic [1:0] is,
                                     input logic pcs, input logic rw, input logic mw,
                                     input logic m2r, input logic as, input logic br,
                                     input logic nw, input logic ud);
    return {c, r, fw, al, rs, is, pcs, rw, mw, m2r, as, br, nw, ud};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(valid_d), 32'(m_valid));
    chk({tag, ".occ"},   32'(occ), 32'(m_cnt));
    chk({tag, ".ready"}, 32'(instr_ready), 32'(m_cnt < DEPTH));
    chk({tag, ".dec"},   32'(act), 32'(m_valid ? m_cur : 25'd0));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt   = 0;
    m_valid = 0;
    m_cur   = '0;
  endtask

  task automatic step(input string tag, input bit v, input int idx, input bit s, input bit f);
    bit p, q;
    instr_valid = v;
    instr       = (idx >= 0) ? t_ins[idx] : 32'hDEAD_BEEF;
    stall       = s;
    flush       = f;
    p = v && (m_cnt < DEPTH) && !f;
    q = !f && (m_cnt > 0) && (!m_valid || !s);
    @(posedge clk);
    #1;
    if (f) begin
      model_reset();
    end else begin
      if (q) begin
        m_cur   = exp_q.pop_front();
        m_valid = 1;
      end else if (!s) begin
        m_valid = 0;
        m_cur   = '0;
      end
      if (p) exp_q.push_back(t_exp[idx]);
      m_cnt = m_cnt + int'(p) - int'(q);
    end
    check_all(tag);
  endtask

  initial begin
    //                     cond  rd    fw     alu     rs     is     pc rw mw mr as br nw ud
    t_ins[0]  = 32'hE082_1003; t_exp[0]  = mk(4'hE, 4'h1, 2'b00, 3'b000, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
    t_ins[1]  = 32'hE350_0005; t_exp[1]  = mk(4'hE, 4'h0, 2'b11, 3'b001, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0);
    t_ins[2]  = 32'hE590_F000; t_exp[2]  = mk(4'hE, 4'hF, 2'b00, 3'b000, 2'b00, 2'b01, 1, 1, 0, 1, 1, 0, 0, 0);
    t_ins[3]  = 32'hEC00_0000; t_exp[3]  = mk(4'hE, 4'h0, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    t_ins[4]  = 32'hE580_1004; t_exp[4]  = mk(4'hE, 4'h1, 2'b00, 3'b000, 2'b10, 2'b01, 0, 0, 1, 0, 1, 0, 0, 0);
    t_ins[5]  = 32'hEA00_0002; t_exp[5]  = mk(4'hE, 4'h0, 2'b00, 3'b000, 2'b01, 2'b10, 1, 0, 0, 0, 1, 1, 0, 0);
    t_ins[6]  = 32'hE051_1002; t_exp[6]  = mk(4'hE, 4'h1, 2'b11, 3'b001, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
    t_ins[7]  = 32'hE100_0001; t_exp[7]  = mk(4'hE, 4'h0, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    t_ins[8]  = 32'hE1A0_F00E; t_exp[8]  = mk(4'hE, 4'hF, 2'b00, 3'b101, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
    t_ins[9]  = 32'h1391_1001; t_exp[9]  = mk(4'h1, 4'h1, 2'b10, 3'b011, 2'b00, 2'b00, 0, 1, 0, 0, 1, 0, 0, 0);
    t_ins[10] = 32'hE061_1002; t_exp[10] = mk(4'hE, 4'h1, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);

    nreset = 1'b0; instr_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    nreset = 1'b1;

    // Back-to-back decode of every table entry, then drain.
    for (int i = 0; i < NT; i++) step("stream", 1, i, 0, 0);
    for (int i = 0; i < 3; i++) step("drain", 0, -1, 0, 0);

    // Spaced pushes show the two-edge push-to-valid latency.
    step("lat.push", 1, 0, 0, 0);
    chk("lat.edge1", 32'(valid_d), 32'd0);
    step("lat.idle", 0, -1, 0, 0);
    chk("lat.edge2", 32'(valid_d), 32'd1);
    step("lat.bubble", 0, -1, 0, 0);

    // Stall with six offers: decode holds first, queue fills, sixth dropped.
    for (int i = 0; i < 6; i++) step("stall", 1, i, 1, 0);
    chk("stall.occ",   32'(occ), 32'd4);
    chk("stall.ready", 32'(instr_ready), 32'd0);
    chk("stall.hold",  32'(act), 32'(t_exp[0]));
    for (int i = 0; i < 7; i++) step("release", 0, -1, 0, 0);

    // Fill under stall, then flush while offering a word.
    for (int i = 6; i < NT; i++) step("fill", 1, i, 1, 0);
    step("flush", 1, 2, 1, 1);
    chk("flush.valid", 32'(valid_d), 32'd0);
    chk("flush.occ",   32'(occ), 32'd0);
    chk("flush.ready", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 2; i++) step("postflush", 0, -1, 0, 0);

    // Asynchronous reset in the middle of traffic.
    step("mid", 1, 4, 0, 0);
    step("mid", 1, 5, 0, 0);
    step("mid", 1, 6, 1, 0);
    #2;
    nreset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    instr_valid = 1'b0;
    stall = 1'b0;
    #1;
    nreset = 1'b1;
    step("after_rst", 1, 8, 0, 0);
    for (int i = 0; i < 3; i++) step("after_rst", 0, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
